// File: rtl/fastreadout_align_pkg.sv
// Shared constants for the fast-readout aligner supervisor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encodings, default search timeout, retry limit,
// aligner reset length, and the decoded block width.
package fastreadout_align_pkg;

  localparam int          BLOCK_W            = 64;
  localparam logic [23:0] DEF_SEARCH_TIMEOUT = 24'd200000;
  localparam int          DEF_MAX_RETRIES    = 4;
  localparam int          DEF_RESET_CYCLES   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RST    = 3'd1,
    ST_SEARCH = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAILED = 3'd4
  } align_state_t;

endpackage

// File: rtl/align_timeout_counter.sv
// Search-attempt timer: counts clock cycles while run is high and flags the last one.
// Latency: tc asserts in the cycle where the count equals LIMIT-1 (count registered).
// Backpressure: none; clear has priority over run.
// Ports: clock, reset (async active-low), clear, run, tc (terminal-count flag).
module align_timeout_counter #(
  parameter int           W     = 24,
  parameter logic [W-1:0] LIMIT = '1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tc
);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == LIMIT - W'(1));

endmodule

// File: rtl/triggered_alignment_controller.sv
// Supervises one triggered_data_aligner lane: reset/search/retest sequencing, retry, lock-loss.
// Latency: control outputs registered, 1 cycle; data_valid 2 cycles after a block_update rise.
// Backpressure: none; strobes are fire-and-forget, downstream must accept every data_valid.
// Ports: clock/reset (async active-low); enable, force_realign, debug_en control inputs;
//   al_* connect to the aligner; data_out/data_valid downstream; state/locked/failed/
//   retry_count/lockloss_count status. Build macro ALIGN_CTRL_STATS_EN enables lockloss_count.
module triggered_alignment_controller
  import fastreadout_align_pkg::*;
#(
  parameter int                   TIMEOUT_W      = 24,
  parameter logic [TIMEOUT_W-1:0] SEARCH_TIMEOUT = TIMEOUT_W'(DEF_SEARCH_TIMEOUT),
  parameter int                   MAX_RETRIES    = DEF_MAX_RETRIES,
  parameter int                   RESET_CYCLES   = DEF_RESET_CYCLES
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               force_realign,
  input  logic               debug_en,
  input  logic               al_block_update,
  input  logic               al_found,
  input  logic [BLOCK_W-1:0] al_dataout,
  output logic               al_reset,
  output logic               al_realign,
  output logic               al_shortsearch,
  output logic               al_debug,
  output logic [BLOCK_W-1:0] data_out,
  output logic               data_valid,
  output logic [2:0]         state,
  output logic               locked,
  output logic               failed,
  output logic [3:0]         retry_count,
  output logic [15:0]        lockloss_count
);

  align_state_t       st, st_d;
  logic               restart, retry_inc, tmo_tc, first;
  logic [3:0]         rst_cnt;
  logic               bu_q1, bu_q2;
  logic [BLOCK_W-1:0] dat_q;
  logic               strobe;

  // Timer is held at zero outside SEARCH, so every entry into SEARCH starts a fresh attempt.
  align_timeout_counter #(.W(TIMEOUT_W), .LIMIT(SEARCH_TIMEOUT)) u_tmo (
    .clock (clock),
    .reset (reset),
    .clear (st != ST_SEARCH),
    .run   (st == ST_SEARCH),
    .tc    (tmo_tc)
  );

  // Next state. Priority: enable low, then force_realign, then lock, then timeout.
  always_comb begin
    st_d      = st;
    restart   = 1'b0;
    retry_inc = 1'b0;
    if (!enable) begin
      st_d = ST_IDLE;
    end else if (st == ST_IDLE || force_realign) begin
      st_d    = ST_RST;
      restart = 1'b1;
    end else begin
      case (st)
        ST_RST:    if (rst_cnt == 4'(RESET_CYCLES - 1)) st_d = ST_SEARCH;
        ST_SEARCH: begin
          if (al_found) begin
            st_d = ST_LOCKED;
          end else if (tmo_tc) begin
            retry_inc = 1'b1;
            st_d = (retry_count + 4'd1 == 4'(MAX_RETRIES)) ? ST_FAILED : ST_RST;
          end
        end
        ST_LOCKED: if (!al_found) st_d = ST_SEARCH;
        default:   st_d = st;
      endcase
    end
  end

  // Block_update edge is taken on registered copies; data is delayed alongside it.
  // A strobe is only issued when the qualifying state is held through this cycle,
  // so an edge landing in the exit cycle is dropped.
  assign strobe = bu_q1 && !bu_q2 &&
                  ((st == ST_LOCKED && st_d == ST_LOCKED) ||
                   (al_debug && st == ST_SEARCH && st_d == ST_SEARCH));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st             <= ST_IDLE;
      rst_cnt        <= '0;
      retry_count    <= '0;
      first          <= 1'b0;
      al_reset       <= 1'b1;
      al_realign     <= 1'b0;
      al_shortsearch <= 1'b0;
      al_debug       <= 1'b0;
      locked         <= 1'b0;
      failed         <= 1'b0;
      bu_q1          <= 1'b0;
      bu_q2          <= 1'b0;
      dat_q          <= '0;
      data_out       <= '0;
      data_valid     <= 1'b0;
    end else begin
      st <= st_d;
      // Cycle counter for the aligner reset pulse; restarts on every entry to RST.
      rst_cnt <= (restart || st != ST_RST || st_d != ST_RST) ? 4'd0 : rst_cnt + 4'd1;
      if (restart) begin
        retry_count <= '0;
        first       <= 1'b1;
      end else if (retry_inc) begin
        retry_count <= retry_count + 4'd1;
        first       <= 1'b0;
      end
      al_reset   <= (st_d == ST_IDLE) || (st_d == ST_RST) || (st_d == ST_FAILED);
      al_realign <= (st_d == ST_LOCKED);
      // Only the very first attempt of a sequence does a full search; a re-search
      // after lock loss always uses the short search.
      if (st_d != ST_SEARCH)     al_shortsearch <= 1'b0;
      else if (st == ST_LOCKED)  al_shortsearch <= 1'b1;
      else if (st != ST_SEARCH)  al_shortsearch <= ~first;
      al_debug   <= (st_d == ST_SEARCH) && debug_en;
      locked     <= (st_d == ST_LOCKED);
      failed     <= (st_d == ST_FAILED);
      bu_q1      <= al_block_update;
      bu_q2      <= bu_q1;
      dat_q      <= al_dataout;
      data_valid <= strobe;
      if (strobe) data_out <= dat_q;
    end
  end

  assign state = st;

`ifdef ALIGN_CTRL_STATS_EN
  logic [15:0] lockloss_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lockloss_q <= '0;
    end else if (st == ST_LOCKED && st_d == ST_SEARCH && lockloss_q != 16'hFFFF) begin
      lockloss_q <= lockloss_q + 16'd1;
    end
  end

  assign lockloss_count = lockloss_q;
`else
  assign lockloss_count = 16'd0;
`endif

endmodule
